prime_fifo: RTL and testbench
=============================

# prime_fifo

Buffering stage between the prime candidate generator and the prime feed stage. It accepts WIDTH-bit primes over a valid/ready write port and presents them on a standard-FIFO read port (rd_en / dout / empty), with one-cycle registered read latency. The read side drives the `fifo_rd_en` / `fifo_dout` / `fifo_empty` connections of the p/q/r/s loader.

## Interface
- WIDTH, 512: prime word width in bits.
- DEPTH_LOG2, 3: log2 of storage depth (default 8 entries).

- aclk  in  1  clock. All logic is rising-edge.
- aresetn  in  1  reset, synchronous, active-low.
- s_valid  in  1  write word valid.
- s_data  in  WIDTH  prime word to write.
- s_ready  out  1  block can accept a word. Equals aresetn && !full.
- rd_en  in  1  read request.
- dout  out  WIDTH  registered read data.
- empty  out  1  no stored words.
- full  out  1  count == 2^DEPTH_LOG2.
- count  out  DEPTH_LOG2+1  number of stored words.
- underflow  out  1  sticky; set by rd_en while empty.
- drop_cnt  out  16  number of duplicate words discarded. Saturates at 16'hFFFF.

## Operation
- Storage is a circular buffer of 2^DEPTH_LOG2 words.
- wr_ptr and rd_ptr are DEPTH_LOG2 bits wide and wrap modulo depth. count is kept as a separate register.
- Write fires when s_valid && s_ready. The word goes to mem[wr_ptr] and wr_ptr increments, unless the duplicate filter discards it (see Configuration).
- Read fires when rd_en && !empty. On the next edge dout <= mem[rd_ptr] and rd_ptr increments.
- dout holds its value when no read fires.
- rd_en while empty:
  - the read is ignored;
  - pointers, count and dout are unchanged;
  - underflow <= 1 and stays set until reset.
- count update, per cycle:
  - stored write, no read: +1;
  - read, no stored write: -1;
  - both, or neither: unchanged.
- Write and read in the same cycle:
  - Both fire independently when neither is blocked.
  - When empty, a same-cycle write does not bypass to dout. The read is an underflow.
  - When full, s_ready is 0, so no write fires; the read proceeds.
- empty and full are decoded from count and update in the same edge as count.
- Reset (aresetn low at a clock edge, including mid-operation):
  - pointers, count, dout, underflow, drop_cnt and the last-word tracker clear;
  - empty = 1, full = 0, s_ready = 0;
  - stored words are lost; mem contents are don't-care.

## Timing
- Write to empty deassert: 1 cycle. empty falls on the edge that stores the first word.
- Read latency: 1 cycle. rd_en sampled at edge N gives valid dout after edge N, usable at edge N+1.
- Back-to-back reads at one word per cycle are supported.
- Back-to-back writes at one word per cycle are supported until full.
- s_ready is combinational from registered full and aresetn only. There is no s_valid -> s_ready path.
- First cycle after aresetn rises: s_ready = 1.

## Configuration
- Macro: PRIME_FIFO_DUP_FILTER_EN.
- Defined:
  - The block holds last_word (WIDTH) and last_valid.
  - An accepted handshake whose s_data == last_word with last_valid = 1 is discarded. It is not stored, s_ready still completes the handshake, and drop_cnt increments (saturating).
  - Every stored word updates last_word and sets last_valid.
  - last_valid clears only on reset. It is not cleared by reads or by empty.
- Undefined:
  - Every accepted word is stored.
  - No comparator or last_word register is built.
  - drop_cnt is tied to 0.

## Test plan
- Reset, then write 11, 13, 17 on consecutive cycles, then pulse rd_en 3 cycles. Required: dout = 11, 13, 17 one cycle after each rd_en; empty returns to 1; count = 0.
- Write 9 words with s_valid held high, DEPTH_LOG2 = 3. Required: 8 words accepted; full = 1; s_ready = 0 on the 9th; count = 8. One read then lets the 9th word enter.
- Fill 6, read 6, then write and read 5 more. Required: wrap-around order preserved (values 1..11 in order); no underflow.
- rd_en while empty, with a same-cycle write of 23. Required: underflow = 1 (sticky); dout unchanged; count = 1; the next rd_en yields 23.
- With PRIME_FIFO_DUP_FILTER_EN, write 29, 29, 31, 29. Required: stored 29, 31, 29; drop_cnt = 1; count = 3. Without the macro: count = 4, drop_cnt = 0.
- Assert aresetn low for one cycle while count = 5. Required: count = 0, empty = 1, dout = 0, underflow = 0, drop_cnt = 0; s_ready = 1 on the next cycle.

Source files
------------

// File: rtl/prime_fifo_if.sv
// prime_fifo_if: write port (valid/ready), standard-FIFO read port and
// status for the prime buffering stage.
//
// Write handshake: a word transfers on every rising aclk edge where
// s_valid && s_ready. The producer holds s_data stable while s_valid is
// high. s_ready never depends on s_valid. Read port: rd_en is a request.
// When it is honoured (empty low), dout updates on the following edge.
interface prime_fifo_if #(
  parameter int WIDTH      = 512,
  parameter int DEPTH_LOG2 = 3
);
  logic                  s_valid;
  logic [WIDTH-1:0]      s_data;
  logic                  s_ready;
  logic                  rd_en;
  logic [WIDTH-1:0]      dout;
  logic                  empty;
  logic                  full;
  logic [DEPTH_LOG2:0]   count;
  logic                  underflow;
  logic [15:0]           drop_cnt;

  modport master (
    output s_valid, s_data, rd_en,
    input  s_ready, dout, empty, full, count, underflow, drop_cnt
  );

  modport slave (
    input  s_valid, s_data, rd_en,
    output s_ready, dout, empty, full, count, underflow, drop_cnt
  );
endinterface

// File: rtl/prime_fifo.sv
// prime_fifo: circular-buffer FIFO between the prime generator and the
// p/q/r/s loader. Registered read data (one-cycle latency), sticky
// underflow flag, separate occupancy counter.
// Optional macro PRIME_FIFO_DUP_FILTER_EN: discard a written word equal to
// the last stored word and count the discards in drop_cnt.
// WIDTH / DEPTH_LOG2 must match the parameters of the connected interface.
module prime_fifo #(
  parameter int WIDTH      = 512,
  parameter int DEPTH_LOG2 = 3
) (
  input  logic         aclk,
  input  logic         aresetn,
  prime_fifo_if.slave  bus
);
  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0]   CNT_FULL = (DEPTH_LOG2+1)'(DEPTH);
  localparam logic [DEPTH_LOG2:0]   CNT_ONE  = (DEPTH_LOG2+1)'(1);
  localparam logic [DEPTH_LOG2-1:0] PTR_ONE  = DEPTH_LOG2'(1);

  logic [WIDTH-1:0]      mem [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr;
  logic [DEPTH_LOG2-1:0] rd_ptr;
  logic [DEPTH_LOG2:0]   count_q;
  logic [WIDTH-1:0]      dout_q;
  logic                  underflow_q;
  logic                  full_w;
  logic                  empty_w;
  logic                  wr_fire;
  logic                  store;
  logic                  rd_fire;

  // Flags decode from the registered count, so s_ready has no path from s_valid.
  assign full_w  = (count_q == CNT_FULL);
  assign empty_w = (count_q == '0);
  assign wr_fire = bus.s_valid && bus.s_ready;
  assign rd_fire = bus.rd_en && !empty_w;

  assign bus.s_ready   = aresetn && !full_w;
  assign bus.full      = full_w;
  assign bus.empty     = empty_w;
  assign bus.count     = count_q;
  assign bus.dout      = dout_q;
  assign bus.underflow = underflow_q;

`ifdef PRIME_FIFO_DUP_FILTER_EN
  logic [WIDTH-1:0] last_word;
  logic             last_valid;
  logic [15:0]      drop_q;
  logic             dup;

  assign dup          = last_valid && (bus.s_data == last_word);
  assign store        = wr_fire && !dup;
  assign bus.drop_cnt = drop_q;

  // Track the last stored word; a matching handshake is consumed but dropped.
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      last_word  <= '0;
      last_valid <= 1'b0;
      drop_q     <= '0;
    end else if (wr_fire) begin
      if (dup) begin
        if (drop_q != 16'hFFFF) drop_q <= drop_q + 16'd1;
      end else begin
        last_word  <= bus.s_data;
        last_valid <= 1'b1;
      end
    end
  end
`else
  assign store        = wr_fire;
  assign bus.drop_cnt = 16'h0;
`endif

  // Storage array; contents are don't-care after reset, so no reset here.
  always_ff @(posedge aclk) begin
    if (store) mem[wr_ptr] <= bus.s_data;
  end

  // Pointers, occupancy, registered read data and the sticky underflow flag.
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count_q     <= '0;
      dout_q      <= '0;
      underflow_q <= 1'b0;
    end else begin
      if (store) wr_ptr <= wr_ptr + PTR_ONE;
      if (rd_fire) begin
        dout_q <= mem[rd_ptr];
        rd_ptr <= rd_ptr + PTR_ONE;
      end
      if (bus.rd_en && empty_w) underflow_q <= 1'b1;
      case ({store, rd_fire})
        2'b10:   count_q <= count_q + CNT_ONE;
        2'b01:   count_q <= count_q - CNT_ONE;
        default: count_q <= count_q;
      endcase
    end
  end
endmodule

// File: tb/tb_prime_fifo.sv
// tb_prime_fifo: randomized and directed stimulus against a queue-based
// reference model; read results are pushed to exp_q and checked by a
// separate monitor when registered dout becomes valid.
module tb_prime_fifo;
  localparam int W  = 64;
  localparam int DL = 3;
  localparam int DEPTH = 1 << DL;

  logic aclk;
  logic aresetn;

  prime_fifo_if #(.WIDTH(W), .DEPTH_LOG2(DL)) bus ();

  prime_fifo #(.WIDTH(W), .DEPTH_LOG2(DL)) dut (
    .aclk    (aclk),
    .aresetn (aresetn),
    .bus     (bus)
  );

  // clock / reset
  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  int checks;
  int errors;

  // reference model state
  logic [W-1:0] mq[$];
  logic [W-1:0] exp_q[$];
  logic [W-1:0] m_dout;
  logic         m_under;
  int           m_drop;
  logic [W-1:0] m_last;
  logic         m_last_valid;
  logic         rd_pending;

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void model_clear();
    mq.delete();
    m_dout       = '0;
    m_under      = 1'b0;
    m_drop       = 0;
    m_last       = '0;
    m_last_valid = 1'b0;
  endfunction

  // Monitor: registered read data appears after the edge that sampled rd_en.
  always @(negedge aclk) begin
    if (rd_pending) begin
      rd_pending = 1'b0;
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL dout_read actual=%0h required=<no expected word>", bus.dout);
      end else begin
        chk("dout_read", bus.dout, exp_q.pop_front());
      end
    end
  end

  // Driver: one cycle of stimulus; status checked against the model first.
  task automatic step(input logic wv, input logic [W-1:0] wd, input logic re);
    bit wr_ok, rd_ok, dup;
    #1;
    bus.s_valid = wv;
    bus.s_data  = wd;
    bus.rd_en   = re;
    #1;
    chk("s_ready",   W'(bus.s_ready),   W'(mq.size() < DEPTH));
    chk("count",     W'(bus.count),     W'(mq.size()));
    chk("empty",     W'(bus.empty),     W'(mq.size() == 0));
    chk("full",      W'(bus.full),      W'(mq.size() == DEPTH));
    chk("underflow", W'(bus.underflow), W'(m_under));
    chk("drop_cnt",  W'(bus.drop_cnt),  W'(m_drop));
    chk("dout_hold", bus.dout,          m_dout);
    wr_ok = wv && (mq.size() < DEPTH);
    rd_ok = re && (mq.size() > 0);
    dup = 1'b0;
`ifdef PRIME_FIFO_DUP_FILTER_EN
    dup = m_last_valid && (wd == m_last);
`endif
    if (re && !rd_ok) m_under = 1'b1;
    if (rd_ok) begin
      m_dout = mq.pop_front();
      exp_q.push_back(m_dout);
    end
    if (wr_ok) begin
      if (dup) begin
        if (m_drop < 65535) m_drop++;
      end else begin
        mq.push_back(wd);
        m_last       = wd;
        m_last_valid = 1'b1;
      end
    end
    @(posedge aclk);
    if (rd_ok) rd_pending = 1'b1;
  endtask

  task automatic do_reset();
    #1;
    aresetn     = 1'b0;
    bus.s_valid = 1'b0;
    bus.rd_en   = 1'b0;
    #1;
    chk("s_ready_in_reset", W'(bus.s_ready), W'(0));
    @(posedge aclk);
    model_clear();
    #1;
    aresetn = 1'b1;
  endtask

  task automatic drain();
    while (mq.size() > 0) step(1'b0, '0, 1'b1);
    step(1'b0, '0, 1'b0);
  endtask

  initial begin
    checks      = 0;
    errors      = 0;
    rd_pending  = 1'b0;
    aresetn     = 1'b0;
    bus.s_valid = 1'b0;
    bus.s_data  = '0;
    bus.rd_en   = 1'b0;
    model_clear();
    do_reset();
    step(1'b0, '0, 1'b0);

    // three words then three reads
    step(1'b1, 64'd11, 1'b0);
    step(1'b1, 64'd13, 1'b0);
    step(1'b1, 64'd17, 1'b0);
    for (int i = 0; i < 3; i++) step(1'b0, '0, 1'b1);
    step(1'b0, '0, 1'b0);

    // fill past depth with s_valid held; 9th word waits for one read
    for (int i = 0; i < DEPTH + 1; i++) step(1'b1, W'(100 + i), 1'b0);
    step(1'b1, W'(100 + DEPTH), 1'b1);
    step(1'b1, W'(100 + DEPTH), 1'b0);
    drain();

    // wrap-around: fill 6, read 6, then write/read 5 more
    for (int i = 1; i <= 6; i++) step(1'b1, W'(i), 1'b0);
    for (int i = 0; i < 6; i++) step(1'b0, '0, 1'b1);
    for (int i = 7; i <= 11; i++) begin
      step(1'b1, W'(i), 1'b0);
      step(1'b0, '0, 1'b1);
    end
    step(1'b0, '0, 1'b0);

    // read while empty with same-cycle write
    step(1'b1, 64'd23, 1'b1);
    step(1'b0, '0, 1'b1);
    step(1'b0, '0, 1'b0);

    // duplicate filter sequence
    step(1'b1, 64'd29, 1'b0);
    step(1'b1, 64'd29, 1'b0);
    step(1'b1, 64'd31, 1'b0);
    step(1'b1, 64'd29, 1'b0);
    drain();

    // reset with five stored words
    for (int i = 0; i < 5; i++) step(1'b1, W'(200 + i), 1'b0);
    step(1'b0, '0, 1'b1);
    step(1'b1, 64'd205, 1'b0);
    do_reset();
    step(1'b0, '0, 1'b0);
    step(1'b0, '0, 1'b1);

    // randomized traffic, small value range so duplicates occur
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 199) == 0) begin
        do_reset();
      end else begin
        step(1'($urandom_range(0, 99) < 60), W'($urandom_range(0, 7)),
             1'($urandom_range(0, 99) < 45));
      end
    end
    drain();

    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL exp_q_drained actual=%0d required=0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
